// File: rtl/simple_rf2_pkg.sv
// Shared widths, FSM state type and write-queue entry layout for the
// write-side controller of the 8x6 register file.
package simple_rf2_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 6;
  localparam int unsigned DEPTH  = 8;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/simple_rf2_wq.sv
// Small write queue: FIFO of {addr, data} entries with head output and a
// newest-first address-match bypass used to forward queued data to reads.
module simple_rf2_wq
  import simple_rf2_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PTR_W = $clog2(QDEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wq_entry_t         push_entry,
  input  logic              pop,
  output wq_entry_t         head,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match_hit,
  output logic [DATA_W-1:0] match_data
);

  wq_entry_t        mem [QDEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_entry;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign full  = (count == CNT_W'(QDEPTH));
  assign empty = (count == '0);
  assign head  = mem[head_ptr];

  // Walk oldest to newest so the last hit (newest entry) wins.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[idx].addr == match_addr)) begin
        match_hit  = 1'b1;
        match_data = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/simple_rf2_wr_ctrl.sv
// Write-side controller owning both RF ports: zero sweep after reset, then
// queued writes drained one per cycle with read forwarding of queued data.
module simple_rf2_wr_ctrl #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_din,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_q
);

  import simple_rf2_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] sweep;
  logic              run;
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  wq_entry_t         head;
  wq_entry_t         push_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      sweep <= '0;
    end else if (state == INIT) begin
      sweep <= sweep + 1'b1;
      if (sweep == ADDR_W'(DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Reset is folded in so outputs read as idle during the reset cycle itself.
  assign run        = (state == RUN) && !reset;
  assign init_done  = run;
  assign wr_ready   = run && !q_full;
  assign push       = wr_valid && wr_ready;
  assign pop        = run && !q_empty;
  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign rf_raddr   = rd_addr;

  simple_rf2_wq #(
    .QDEPTH(QDEPTH)
  ) u_wq (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty),
    .match_addr (rd_addr),
    .match_hit  (hit),
    .match_data (hit_data)
  );

  always_comb begin
    rf_waddr = '0;
    rf_din   = '0;
    rd_data  = '0;
    if (!reset) begin
      if (state == INIT) begin
        rf_waddr = sweep;
      end else begin
        if (q_empty) begin
          rf_waddr = rd_addr;
          rf_din   = rf_q;
        end else begin
          rf_waddr = head.addr;
          rf_din   = head.data;
        end
        rd_data = hit ? hit_data : rf_q;
      end
    end
  end

endmodule
